xor_stream_checksum: RTL

//  Parametrised, sequential successor to the 2-input XOR gate.

---
 rtl/xor_stream_checksum.sv | 102 ++++++++++
 1 files changed

// File: rtl/xor_stream_checksum.sv
// Framed XOR checksum with valid/ready handshakes on both sides.
// Generate mode emits the fold; check mode flags a nonzero fold.
module xor_stream_checksum #(
  parameter  int WIDTH   = 8,
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic             out_parity,
  output logic [LEN_W-1:0] out_len,
  output logic             out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [LEN_W-1:0] len;
  logic             ovf;
  logic             mode_q;

  logic             accept;
  logic             first;
  logic             full;
  logic [WIDTH-1:0] nxt_acc;
  logic [LEN_W-1:0] nxt_len;
  logic             nxt_ovf;
  logic             nxt_mode;

  assign in_ready  = ~rst & (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid & in_ready;

  // The first word of a frame reseeds the fold instead of extending it.
  always_comb begin
    first    = (state == IDLE);
    full     = (len == LEN_W'(MAX_LEN));
    nxt_acc  = first ? in_data : (acc ^ in_data);
    nxt_len  = len;
    nxt_ovf  = ovf | full;
    nxt_mode = mode_q;
    if (first) begin
      nxt_len  = LEN_W'(1);
      nxt_ovf  = 1'b0;
      nxt_mode = mode;
    end else if (!full) begin
      nxt_len = len + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      len        <= '0;
      ovf        <= 1'b0;
      mode_q     <= 1'b0;
      out_xor    <= '0;
      out_parity <= 1'b0;
      out_len    <= '0;
      out_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc    <= nxt_acc;
            len    <= nxt_len;
            ovf    <= nxt_ovf;
            mode_q <= nxt_mode;
            if (in_last) begin
              state      <= HOLD;
              out_xor    <= nxt_acc;
              out_parity <= ^nxt_acc;
              out_len    <= nxt_len;
              out_err    <= nxt_ovf | (nxt_mode & (|nxt_acc));
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
